// File: rtl/relu_serializer.sv
// relu_serializer
//   Captures a full parallel result vector from a linear layer and streams it
//   out one element per cycle, optionally applying ReLU, as the serial input
//   of the next layer. The capture buffer frees the upstream layer to start
//   its next accumulation as soon as a vector is accepted.
//
// Parameters
//   DATA_WIDTH : element width (two's complement)
//   NUM_NODES  : elements per vector
//   RELU_EN    : 1 = clamp negative elements to 0, 0 = pass through
//
// Ports
//   clk      : clock
//   rst      : synchronous active-high reset
//   i_valid  : one-cycle pulse, din holds a complete vector
//   din      : unpacked array of NUM_NODES elements
//   dout     : current serialized activation (0 when o_valid = 0)
//   o_valid  : dout valid this cycle
//   o_last   : dout carries element NUM_NODES-1
//   busy     : a vector is being streamed (same cycles as o_valid)
//   overrun  : sticky, an i_valid was dropped; cleared only by rst
module relu_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_NODES  = 500,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      idx_inc;
    logic [DATA_WIDTH-1:0] cap_q [NUM_NODES];
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  valid_d, last_d, ovr_d;
    logic                  accept;
    logic                  load;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
        if ((RELU_EN != 0) && x[DATA_WIDTH-1])
            return '0;
        return x;
    endfunction

    // A new vector fits when nothing is streaming, or when the final element
    // leaves this cycle; the latter gives gap-free back-to-back vectors.
    assign accept  = i_valid && ((state_q == IDLE) || o_last);
    assign idx_inc = idx_q + 1'b1;

    // idx_q is the index of the element currently on dout. Outputs are
    // registered, so the next element is looked up one cycle ahead; on accept
    // element 0 comes straight from din since the buffer is loading the same
    // edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dout_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        ovr_d   = overrun;
        load    = 1'b0;
        if (accept) begin
            load    = 1'b1;
            state_d = STREAM;
            idx_d   = '0;
            dout_d  = relu(din[0]);
            valid_d = 1'b1;
            last_d  = (NUM_NODES == 1);
        end else begin
            if (i_valid)
                ovr_d = 1'b1;
            if (state_q == STREAM) begin
                if (o_last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_inc;
                    dout_d  = relu(cap_q[idx_inc]);
                    valid_d = 1'b1;
                    last_d  = (idx_inc == LAST_IDX);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dout    <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dout    <= dout_d;
            o_valid <= valid_d;
            o_last  <= last_d;
            busy    <= valid_d;
            overrun <= ovr_d;
        end
    end

    // Capture buffer carries no reset; its contents only matter after a load.
    always_ff @(posedge clk) begin
        if (load && !rst)
            cap_q <= din;
    end

endmodule

// File: tb/tb_relu_serializer.sv
module tb_relu_serializer;

    typedef logic [7:0] vec_t [4];

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    vec_t       din;
    logic [7:0] dout_r, dout_p;
    logic       ov_r, ol_r, bz_r, or_r;
    logic       ov_p, ol_p, bz_p, or_p;
    logic [11:0] obs, expv;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vec_a      = '{8'h05, 8'h80, 8'h7F, 8'hFF};
    vec_t vec_b      = '{8'h01, 8'h02, 8'h03, 8'h04};
    vec_t exp_a_relu = '{8'h05, 8'h00, 8'h7F, 8'h00};
    vec_t exp_a_pass = '{8'h05, 8'h80, 8'h7F, 8'hFF};

    always #5 clk = ~clk;

    relu_serializer #(.DATA_WIDTH(8), .NUM_NODES(4), .RELU_EN(1)) dut_relu (
        .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
        .dout(dout_r), .o_valid(ov_r), .o_last(ol_r), .busy(bz_r), .overrun(or_r)
    );

    relu_serializer #(.DATA_WIDTH(8), .NUM_NODES(4), .RELU_EN(0)) dut_pass (
        .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
        .dout(dout_p), .o_valid(ov_p), .o_last(ol_p), .busy(bz_p), .overrun(or_p)
    );

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; din = vec_a;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {dout_r, ov_r, ol_r, bz_r, or_r};
            n_checks++;
            if (obs !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got %h exp %h", c, obs, 12'h000);
            end
        end
        rst = 1'b0; i_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {dout_r, ov_r, ol_r, bz_r, or_r};
            n_checks++;
            if (obs !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got %h exp %h", c, obs, 12'h000);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        din = vec_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs  = {dout_r, ov_r, ol_r, bz_r, or_r};
            expv = {exp_a_relu[k], 1'b1, (k == 3), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single_relu k=%0d got %h exp %h", k, obs, expv);
            end
            obs  = {dout_p, ov_p, ol_p, bz_p, or_p};
            expv = {exp_a_pass[k], 1'b1, (k == 3), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single_pass k=%0d got %h exp %h", k, obs, expv);
            end
            step();
        end
        obs = {dout_r, ov_r, ol_r, bz_r, or_r};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL single_end got %h exp %h", obs, 12'h000);
        end
        obs = {dout_p, ov_p, ol_p, bz_p, or_p};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL single_end_pass got %h exp %h", obs, 12'h000);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        din = vec_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            // Second vector offered exactly on the o_last cycle of the first.
            if (k == 3) begin
                din = vec_b; i_valid = 1'b1;
            end
            obs  = {dout_r, ov_r, ol_r, bz_r, or_r};
            expv = {(k < 4) ? exp_a_relu[k] : vec_b[k-4], 1'b1, (k == 3 || k == 7), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b k=%0d got %h exp %h", k, obs, expv);
            end
            step();
            i_valid = 1'b0;
        end
        obs = {dout_r, ov_r, ol_r, bz_r, or_r};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL b2b_end got %h exp %h", obs, 12'h000);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        din = vec_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs  = {dout_r, ov_r, ol_r, bz_r, or_r};
            expv = {exp_a_relu[k], 1'b1, (k == 3), 1'b1, (k >= 2)};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL overrun k=%0d got %h exp %h", k, obs, expv);
            end
            // Mid-stream request: must be dropped and flagged.
            if (k == 1) begin
                din = vec_b; i_valid = 1'b1;
            end
            step();
            i_valid = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            obs = {dout_r, ov_r, ol_r, bz_r, or_r};
            n_checks++;
            if (obs !== 12'h001) begin
                n_fail++;
                $display("FAIL overrun_sticky c=%0d got %h exp %h", c, obs, 12'h001);
            end
            step();
        end
        do_reset();
        obs = {dout_r, ov_r, ol_r, bz_r, or_r};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL overrun_clear got %h exp %h", obs, 12'h000);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        din = vec_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        rst = 1'b1; i_valid = 1'b1;
        step();
        obs = {dout_r, ov_r, ol_r, bz_r, or_r};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_abort got %h exp %h", obs, 12'h000);
        end
        rst = 1'b0; din = vec_b; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs  = {dout_r, ov_r, ol_r, bz_r, or_r};
            expv = {vec_b[k], 1'b1, (k == 3), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL midrst_restream k=%0d got %h exp %h", k, obs, expv);
            end
            step();
        end
        obs = {dout_r, ov_r, ol_r, bz_r, or_r};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_end got %h exp %h", obs, 12'h000);
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; din = vec_a;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
